// File: rtl/pcie_rr_sched.sv
// rtl/pcie_rr_sched.sv - PCIe read-request scheduler: 512 B requests, 8-tag pool, FIFO credit gating
module pcie_rr_sched (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        enable,
    input  logic [63:0] base_addr,
    input  logic [21:0] block_count,
    input  logic [15:0] fifo_space,
    output logic        rr_valid,
    output logic [63:0] rr_addr,
    output logic [7:0]  rr_tag,
    input  logic        rr_ready,
    input  logic        tag_done_valid,
    input  logic [7:0]  tag_done,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        REQ   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [63:0] r_addr;
    logic [63:0] r_rr_addr;
    logic [21:0] r_remaining;
    logic [7:0]  r_mask;
    logic [2:0]  r_tag;
    logic        r_busy;
    logic        r_done;
    logic        r_error;

    logic [3:0]  w_out_cnt;
    logic        w_free_found;
    logic [2:0]  w_free_tag;
    logic [16:0] w_need;
    logic        w_credit_ok;
    logic        w_grant;
    logic        w_accept;
    logic        w_load;
    logic        w_launch;
    logic        w_finish;
    logic [7:0]  w_rel_bit;
    logic        w_rel_ok;
    logic        w_rel_err;
    logic [7:0]  w_set_bit;
    logic [7:0]  w_mask_next;
    logic        w_unused;

    assign w_unused = ^{tag_done[7:3], base_addr[8:0]};

    // Tag choice and credit use the registered mask, so a tag released this
    // cycle only becomes allocatable from the next cycle on.
    always_comb begin
        w_out_cnt    = '0;
        w_free_found = 1'b0;
        w_free_tag   = '0;
        for (int i = 0; i < 8; i++) begin
            w_out_cnt = w_out_cnt + {3'b000, r_mask[i]};
        end
        for (int i = 7; i >= 0; i--) begin
            if (!r_mask[i]) begin
                w_free_found = 1'b1;
                w_free_tag   = 3'(i);
            end
        end
    end

    assign w_need      = {7'b0, w_out_cnt + 4'd1, 6'b0};
    assign w_credit_ok = ({1'b0, fifo_space} >= w_need);
    assign w_grant     = enable && (r_remaining != 22'd0) && w_free_found && w_credit_ok;
    assign w_accept    = (r_state == REQ) && rr_ready;

    assign w_rel_bit   = 8'b1 << tag_done[2:0];
    assign w_rel_ok    = tag_done_valid && ((r_mask & w_rel_bit) != 8'b0);
    assign w_rel_err   = tag_done_valid && ((r_mask & w_rel_bit) == 8'b0);
    assign w_set_bit   = w_accept ? (8'b1 << r_tag) : 8'b0;
    assign w_mask_next = (r_mask | w_set_bit) & ~(w_rel_ok ? w_rel_bit : 8'b0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_launch     = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = (block_count == 22'd0) ? DRAIN : ARM;
                end
            end
            ARM: begin
                if (w_grant) begin
                    w_launch     = 1'b1;
                    w_state_next = REQ;
                end
            end
            REQ: begin
                if (rr_ready) begin
                    w_state_next = (r_remaining == 22'd1) ? DRAIN : ARM;
                end
            end
            DRAIN: begin
                if (r_mask == 8'b0) begin
                    w_finish     = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_addr      <= '0;
            r_rr_addr   <= '0;
            r_remaining <= '0;
            r_mask      <= '0;
            r_tag       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_done <= w_finish;
            r_mask <= w_mask_next;
            if (w_rel_err) begin
                r_error <= 1'b1;
            end
            if (w_load) begin
                r_addr      <= {base_addr[63:9], 9'b0};
                r_remaining <= block_count;
                r_busy      <= 1'b1;
            end
            if (w_finish) begin
                r_busy <= 1'b0;
            end
            if (w_launch) begin
                r_rr_addr <= r_addr;
                r_tag     <= w_free_tag;
            end
            if (w_accept) begin
                r_addr      <= r_addr + 64'd512;
                r_remaining <= r_remaining - 22'd1;
            end
        end
    end

    assign rr_valid = (r_state == REQ);
    assign rr_addr  = r_rr_addr;
    assign rr_tag   = {5'b00000, r_tag};
    assign busy     = r_busy;
    assign done     = r_done;
    assign error    = r_error;

endmodule

// File: tb/tb_pcie_rr_sched.sv
// tb/tb_pcie_rr_sched.sv - self-checking bench for pcie_rr_sched
`timescale 1ns/1ps
module tb_pcie_rr_sched;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        enable = 1'b0;
    logic [63:0] base_addr = '0;
    logic [21:0] block_count = '0;
    logic [15:0] fifo_space = '0;
    logic        rr_valid;
    logic [63:0] rr_addr;
    logic [7:0]  rr_tag;
    logic        rr_ready = 1'b0;
    logic        tag_done_valid = 1'b0;
    logic [7:0]  tag_done = '0;
    logic        busy;
    logic        done;
    logic        error;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] q_addr[$];
    logic [7:0]  q_tag[$];
    int          done_cnt = 0;
    int          done_busy_cnt = 0;
    int          valid_cnt = 0;

    pcie_rr_sched dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .enable         (enable),
        .base_addr      (base_addr),
        .block_count    (block_count),
        .fifo_space     (fifo_space),
        .rr_valid       (rr_valid),
        .rr_addr        (rr_addr),
        .rr_tag         (rr_tag),
        .rr_ready       (rr_ready),
        .tag_done_valid (tag_done_valid),
        .tag_done       (tag_done),
        .busy           (busy),
        .done           (done),
        .error          (error)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (rr_valid && rr_ready) begin
            q_addr.push_back(rr_addr);
            q_tag.push_back(rr_tag);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            if (busy) done_busy_cnt = done_busy_cnt + 1;
        end
        if (rr_valid) valid_cnt = valid_cnt + 1;
    end

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic clear_mon();
        q_addr.delete();
        q_tag.delete();
        done_cnt = 0;
        done_busy_cnt = 0;
        valid_cnt = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        start = 1'b0;
        enable = 1'b1;
        rr_ready = 1'b1;
        tag_done_valid = 1'b0;
        tag_done = '0;
        fifo_space = 16'hFFFF;
        cycles(2);
        reset = 1'b1;
        cycle();
        clear_mon();
    endtask

    task automatic kick(input logic [63:0] b, input logic [21:0] c);
        base_addr = b;
        block_count = c;
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic rel(input logic [7:0] t);
        tag_done_valid = 1'b1;
        tag_done = t;
        cycle();
        tag_done_valid = 1'b0;
    endtask

    task automatic wait_q(input int n, input int budget);
        for (int k = 0; k < budget && q_addr.size() < n; k++) cycle();
    endtask

    function automatic int lowest_free(input logic [7:0] m);
        for (int i = 0; i < 8; i++) if (!m[i]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        cycles(2);
        n_cmp++; if (rr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rr_valid: got %0b want 0", rr_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %0b want 0", done); end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL reset_error: got %0b want 0", error); end
        n_cmp++; if (rr_addr !== 64'd0) begin n_bad++; $display("FAIL reset_rr_addr: got %h want 0", rr_addr); end
        n_cmp++; if (rr_tag !== 8'd0) begin n_bad++; $display("FAIL reset_rr_tag: got %h want 0", rr_tag); end
    endtask

    task automatic test_single_block();
        do_reset();
        fifo_space = 16'd64;
        kick(64'h1_0000_0200, 22'd1);
        n_cmp++; if (rr_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_valid: got %0b want 0", rr_valid); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %0b want 1", busy); end
        cycle();
        n_cmp++; if (rr_valid !== 1'b1) begin n_bad++; $display("FAIL single_latency_valid: got %0b want 1", rr_valid); end
        cycle();
        n_cmp++; if (q_addr.size() !== 1) begin n_bad++; $display("FAIL single_req_count: got %0d want 1", q_addr.size()); end
        n_cmp++; if (q_addr.size() > 0 && q_addr[0] !== 64'h1_0000_0200) begin n_bad++; $display("FAIL single_addr: got %h want 100000200", q_addr[0]); end
        n_cmp++; if (q_tag.size() > 0 && q_tag[0] !== 8'd0) begin n_bad++; $display("FAIL single_tag: got %0d want 0", q_tag[0]); end
        n_cmp++; if (rr_valid !== 1'b0) begin n_bad++; $display("FAIL single_valid_after_accept: got %0b want 0", rr_valid); end
        cycles(3);
        n_cmp++; if (done_cnt !== 0 || busy !== 1'b1) begin n_bad++; $display("FAIL single_wait_release: done_cnt %0d busy %0b want 0/1", done_cnt, busy); end
        rel(8'd0);
        cycles(5);
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL single_done_pulses: got %0d want 1", done_cnt); end
        n_cmp++; if (done_busy_cnt !== 0 || busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_drop: busy_at_done %0d busy %0b want 0/0", done_busy_cnt, busy); end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL single_error: got %0b want 0", error); end
    endtask

    task automatic test_tag_exhaustion();
        logic [63:0] b;
        b = 64'h0000_0040_0000_0000;
        do_reset();
        kick(b, 22'd10);
        cycles(40);
        n_cmp++; if (q_addr.size() !== 8) begin n_bad++; $display("FAIL exhaust_count: got %0d want 8", q_addr.size()); end
        for (int i = 0; i < 8 && i < q_addr.size(); i++) begin
            n_cmp++; if (q_tag[i] !== 8'(i) || q_addr[i] !== b + 64'(i) * 64'd512) begin
                n_bad++; $display("FAIL exhaust_req%0d: got tag %0d addr %h want tag %0d addr %h", i, q_tag[i], q_addr[i], i, b + 64'(i) * 64'd512);
            end
        end
        n_cmp++; if (rr_valid !== 1'b0) begin n_bad++; $display("FAIL exhaust_stall: rr_valid %0b want 0", rr_valid); end
        rel(8'd3);
        wait_q(9, 20);
        n_cmp++; if (q_addr.size() !== 9) begin n_bad++; $display("FAIL exhaust_after_release_count: got %0d want 9", q_addr.size()); end
        n_cmp++; if (q_addr.size() > 8 && (q_tag[8] !== 8'd3 || q_addr[8] !== b + 64'h1000)) begin
            n_bad++; $display("FAIL exhaust_reuse: got tag %0d addr %h want tag 3 addr %h", q_tag[8], q_addr[8], b + 64'h1000);
        end
    endtask

    task automatic test_credit_limit();
        do_reset();
        fifo_space = 16'd191;
        kick(64'h2000, 22'd4);
        cycles(30);
        n_cmp++; if (q_addr.size() !== 2) begin n_bad++; $display("FAIL credit_191: got %0d requests want 2", q_addr.size()); end
        fifo_space = 16'd192;
        wait_q(3, 20);
        n_cmp++; if (q_addr.size() !== 3) begin n_bad++; $display("FAIL credit_192: got %0d requests want 3", q_addr.size()); end
        n_cmp++; if (q_addr.size() > 2 && q_addr[2] !== 64'h2400) begin n_bad++; $display("FAIL credit_addr: got %h want 2400", q_addr[2]); end
        cycles(20);
        n_cmp++; if (q_addr.size() !== 3) begin n_bad++; $display("FAIL credit_hold_4th: got %0d requests want 3", q_addr.size()); end
    endtask

    task automatic test_backpressure();
        logic [63:0] a;
        logic [7:0]  t;
        do_reset();
        rr_ready = 1'b0;
        kick(64'h8000_0000_0000_0000, 22'd2);
        for (int k = 0; k < 20 && !rr_valid; k++) cycle();
        n_cmp++; if (rr_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid_timeout: got %0b want 1", rr_valid); end
        a = rr_addr;
        t = rr_tag;
        n_cmp++; if (a !== 64'h8000_0000_0000_0000 || t !== 8'd0) begin n_bad++; $display("FAIL bp_first_req: got %h/%0d want 8000000000000000/0", a, t); end
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            n_cmp++; if (rr_valid !== 1'b1 || rr_addr !== a || rr_tag !== t || q_addr.size() !== 0) begin
                n_bad++; $display("FAIL bp_hold%0d: got v %0b addr %h tag %0d acc %0d want 1 %h %0d 0", k, rr_valid, rr_addr, rr_tag, q_addr.size(), a, t);
            end
        end
        rr_ready = 1'b1;
        cycle();
        n_cmp++; if (q_addr.size() !== 1 || rr_valid !== 1'b0) begin n_bad++; $display("FAIL bp_accept: got acc %0d v %0b want 1 0", q_addr.size(), rr_valid); end
        enable = 1'b1;
    endtask

    task automatic test_zero_blocks();
        do_reset();
        kick(64'h4000, 22'd0);
        cycles(6);
        n_cmp++; if (done_cnt !== 1 || valid_cnt !== 0) begin n_bad++; $display("FAIL zero_blocks: done %0d valid_cycles %0d want 1 0", done_cnt, valid_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL zero_busy: got %0b want 0", busy); end
    endtask

    task automatic test_error();
        do_reset();
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL err_initial: got %0b want 0", error); end
        rel(8'd5);
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL err_set: got %0b want 1", error); end
        cycles(5);
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %0b want 1", error); end
    endtask

    task automatic test_wrap();
        do_reset();
        kick(64'hFFFF_FFFF_FFFF_FE00, 22'd2);
        wait_q(2, 20);
        n_cmp++; if (q_addr.size() !== 2) begin n_bad++; $display("FAIL wrap_count: got %0d want 2", q_addr.size()); end
        n_cmp++; if (q_addr.size() > 1 && (q_addr[0] !== 64'hFFFF_FFFF_FFFF_FE00 || q_addr[1] !== 64'd0)) begin
            n_bad++; $display("FAIL wrap_addr: got %h %h want fffffffffffffe00 0", q_addr[0], q_addr[1]);
        end
        rel(8'd0);
        rel(8'd1);
        cycles(4);
        n_cmp++; if (done_cnt !== 1 || error !== 1'b0) begin n_bad++; $display("FAIL wrap_done: done %0d err %0b want 1 0", done_cnt, error); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        kick(64'h10_0000, 22'd3);
        cycles(20);
        n_cmp++; if (q_addr.size() !== 3 || busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_setup: acc %0d busy %0b want 3 1", q_addr.size(), busy); end
        reset = 1'b0;
        cycle();
        n_cmp++; if (rr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || rr_addr !== 64'd0 || rr_tag !== 8'd0) begin
            n_bad++; $display("FAIL rstmid_outputs: v %0b busy %0b done %0b err %0b addr %h tag %0d want all 0", rr_valid, busy, done, error, rr_addr, rr_tag);
        end
        cycle();
        reset = 1'b1;
        cycles(3);
        n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL rstmid_no_done: got %0d want 0", done_cnt); end
        rel(8'd0);
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL rstmid_stale_release: error %0b want 1", error); end
        clear_mon();
        kick(64'h20_0000, 22'd1);
        wait_q(1, 20);
        n_cmp++; if (q_tag.size() !== 1 || q_tag[0] !== 8'd0) begin n_bad++; $display("FAIL rstmid_mask_cleared: got %0d reqs tag %0d want 1 0", q_tag.size(), q_tag.size() > 0 ? q_tag[0] : 8'hFF); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            logic [63:0] b;
            logic [21:0] cnt;
            logic [7:0]  m;
            logic [7:0]  m_snap;
            logic        prev_valid;
            logic [63:0] held_addr;
            logic [7:0]  held_tag;
            int          issued;
            int          dones;
            int          cyc;
            int          exp_tag;
            logic        rel_v;
            int          rel_t;
            do_reset();
            b = {$urandom, $urandom} & ~64'h1FF;
            cnt = 22'($urandom_range(1, 20));
            m = '0; m_snap = '0; prev_valid = 1'b0; issued = 0; dones = 0; cyc = 0;
            held_addr = '0; held_tag = '0;
            kick(b, cnt);
            while (!(issued == int'(cnt) && m == 8'b0) && cyc < 3000) begin
                if (done) dones++;
                if (rr_valid && !prev_valid) begin
                    exp_tag = lowest_free(m_snap);
                    n_cmp++; if (issued >= int'(cnt) || rr_tag !== 8'(exp_tag) || rr_addr !== b + 64'(issued) * 64'd512) begin
                        n_bad++; $display("FAIL rand%0d_req%0d: got tag %0d addr %h want tag %0d addr %h", it, issued, rr_tag, rr_addr, exp_tag, b + 64'(issued) * 64'd512);
                    end
                    held_addr = rr_addr;
                    held_tag = rr_tag;
                end else if (rr_valid) begin
                    n_cmp++; if (rr_addr !== held_addr || rr_tag !== held_tag) begin
                        n_bad++; $display("FAIL rand%0d_hold: got %h/%0d want %h/%0d", it, rr_addr, rr_tag, held_addr, held_tag);
                    end
                end
                rr_ready = ($urandom_range(0, 1) == 1);
                enable = ($urandom_range(0, 4) != 0);
                rel_v = 1'b0; rel_t = 0;
                if (m != 8'b0 && $urandom_range(0, 2) == 0) begin
                    rel_t = $urandom_range(0, 7);
                    while (!m[rel_t]) rel_t = (rel_t + 1) % 8;
                    rel_v = 1'b1;
                end
                tag_done_valid = rel_v;
                tag_done = {5'($urandom), 3'(rel_t)};
                m_snap = m;
                if (rr_valid && rr_ready) begin
                    m[rr_tag[2:0]] = 1'b1;
                    issued++;
                end
                if (rel_v) m[rel_t] = 1'b0;
                prev_valid = rr_valid;
                cycle();
                cyc++;
            end
            tag_done_valid = 1'b0;
            for (int k = 0; k < 5; k++) begin
                if (done) dones++;
                cycle();
            end
            n_cmp++; if (cyc >= 3000) begin n_bad++; $display("FAIL rand%0d_timeout: issued %0d of %0d", it, issued, cnt); end
            n_cmp++; if (dones !== 1 || busy !== 1'b0 || error !== 1'b0) begin
                n_bad++; $display("FAIL rand%0d_end: done %0d busy %0b err %0b want 1 0 0", it, dones, busy, error);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_tag_exhaustion();
        test_credit_limit();
        test_backpressure();
        test_zero_blocks();
        test_error();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pcie_rr_sched.md
PCIE_RR_SCHED -- requirements
Module: pcie_rr_sched

Interface
REQ-001 SHALL have port clock  input  1  the single clock; all logic is on its rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-003 SHALL have port start  input  1  single-cycle pulse that begins a transfer.
REQ-004 SHALL have port enable  input  1  gate; when low, no new request is raised.
REQ-005 SHALL have port base_addr  input  64  host byte address of the transfer, sampled at start; bits [8:0] ignored (treated as 0).
REQ-006 SHALL have port block_count  input  22  number of 512-byte blocks, sampled at start.
REQ-007 SHALL have port fifo_space  input  16  free 64-bit words in the downstream receive FIFO.
REQ-008 SHALL have port rr_valid  output  1  read request valid to the PCIe TX engine.
REQ-009 SHALL have port rr_addr  output  64  request address; always 512-byte aligned.
REQ-010 SHALL have port rr_tag  output  8  request tag: {5'b0, tag[2:0]}.
REQ-011 SHALL have port rr_ready  input  1  TX engine accepts the request when high with rr_valid.
REQ-012 SHALL have port tag_done_valid  input  1  final completion for a tag has been received.
REQ-013 SHALL have port tag_done  input  8  tag being released; bits [7:3] are ignored.
REQ-014 SHALL have port busy  output  1  high while a transfer is in progress.
REQ-015 SHALL have port done  output  1  single-cycle pulse when a transfer has fully completed.
REQ-016 SHALL have port error  output  1  sticky flag: a release was received for a tag that is not outstanding.

Function
REQ-017 Each request SHALL be 128 DW (512 B = 64 words); the address SHALL advance by 512 per accepted request, with 64-bit wrap-around.
REQ-018 Tag pool: 8 tags, tracked by an 8-bit outstanding mask.
  - Allocation SHALL take the lowest-numbered free tag.
  - At most 8 requests SHALL be outstanding.
REQ-019 FSM states IDLE, ARM, REQ, DRAIN; reset state is IDLE.
REQ-020 IDLE: on start, SHALL latch base_addr and block_count, assert busy the next cycle and go to ARM. If block_count == 0, SHALL go directly to DRAIN.
REQ-021 ARM → REQ when all of the following hold in the same cycle:
  - enable = 1
  - blocks remaining > 0
  - at least one free tag
  - fifo_space >= 64*(outstanding count + 1), computed at 17 bits with no truncation.
REQ-022 REQ: rr_valid = 1, with rr_addr and rr_tag registered and held stable until rr_valid & rr_ready.
  - On that handshake, SHALL mark the tag outstanding, decrement the remaining count and advance the address.
  - SHALL then go to ARM if blocks remain, else to DRAIN.
  - rr_valid SHALL be low in the cycle after acceptance, so there is at most one request per 2 cycles.
REQ-023 Latency: start in cycle N SHALL give rr_valid high in cycle N+2 at the earliest.
REQ-024 enable falling while in REQ SHALL NOT withdraw rr_valid; the request is held until it is accepted.
REQ-025 DRAIN: when the outstanding mask is 0, SHALL pulse done for 1 cycle, drop busy in the same cycle and return to IDLE.
REQ-026 tag_done_valid SHALL clear the corresponding mask bit in any state.
  - If that bit is already 0, SHALL set error and leave the mask unchanged.
REQ-027 Simultaneous release and acceptance SHALL both take effect. A tag freed in cycle N SHALL NOT be allocated before cycle N+1.
REQ-028 start while busy SHALL be ignored.
REQ-029 rr_tag[7:3] SHALL always be 0.

Reset
REQ-030 While reset is low at a clock edge, the block SHALL initialise as follows:
  - rr_valid = 0, busy = 0, done = 0, error = 0
  - rr_addr = 0, rr_tag = 0
  - mask = 0, remaining = 0, state = IDLE.
REQ-031 Reset mid-transfer SHALL abandon all outstanding tags without pulsing done. Releases arriving after reset SHALL set error.

Verification
REQ-032 Single block:
  - Stimulus: base_addr=0x1_0000_0200, block_count=1, fifo_space=64, rr_ready=1.
  - Required: one request with rr_addr=0x1_0000_0200 and rr_tag=0; busy high.
  - After tag_done=0: done pulses once, busy drops.
REQ-033 Tag exhaustion:
  - Stimulus: block_count=10, fifo_space=0xFFFF, no releases.
  - Required: exactly 8 requests with tags 0..7 and addresses base+0..base+0xE00, then stall.
  - After releasing tag 3: the next request uses tag 3 at base+0x1000.
REQ-034 Credit limit:
  - Stimulus: fifo_space=191, block_count=4.
  - Required: 2 requests issue, then stall.
  - After fifo_space is raised to 192: a third request issues.
REQ-035 Backpressure:
  - Stimulus: rr_ready=0 for 5 cycles, with enable dropped during them.
  - Required: rr_valid, rr_addr and rr_tag stay constant; acceptance occurs on the first cycle rr_ready=1.
REQ-036 Edge cases:
  - block_count=0 start: done pulses with no rr_valid.
  - Release of a free tag 5: error=1 and stays set.
  - Address wrap: base 0xFFFF_FFFF_FFFF_FE00 with 2 blocks gives a second address of 0x0.
REQ-037 Reset mid-transfer:
  - Stimulus: reset low with 3 tags outstanding.
  - Required: all outputs take their REQ-030 reset values, with no done pulse.
